// File: rtl/sum_accumulator.sv
// rtl/sum_accumulator.sv - block-sum accumulator over a valid/ready stream of {carry, sum} values
// Optional macro SUM_ACC_SAT_EN: saturate the accumulator at all ones instead of wrapping.
module sum_accumulator #(
  parameter int IN_W  = 8,
  parameter int ACC_W = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_sum,
  input  logic             in_carry,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_ovf,
  output logic [CNT_W-1:0] out_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic             ovf_q, ovf_d;

  logic [ACC_W:0]   x_val;
  logic [ACC_W:0]   sum;
  logic [ACC_W-1:0] acc_add;
  logic             beat;
  logic             last_beat;

  // One extra bit above the accumulator catches the carry out of every add.
  assign x_val = {{(ACC_W-IN_W){1'b0}}, in_carry, in_sum};
  assign sum   = {1'b0, acc_q} + x_val;

`ifdef SUM_ACC_SAT_EN
  assign acc_add = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
  assign acc_add = sum[ACC_W-1:0];
`endif

  assign beat      = in_valid && in_ready;
  assign last_beat = (cnt_q == len_q - CNT_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = (len == '0) ? S_DONE : S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (beat && last_beat) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      S_ACCUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      S_DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath registers only move on an accepted start or an accepted beat.
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    len_d = len_q;
    ovf_d = ovf_q;
    if (state_q == S_IDLE && start) begin
      acc_d = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
      len_d = len;
    end else if (beat) begin
      acc_d = acc_add;
      cnt_d = cnt_q + CNT_W'(1);
      ovf_d = ovf_q | sum[ACC_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      cnt_q <= '0;
      len_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      len_q <= len_d;
      ovf_q <= ovf_d;
    end
  end

  assign out_acc   = acc_q;
  assign out_ovf   = ovf_q;
  assign out_count = cnt_q;

endmodule
